// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: mouse byte-index states, header bit positions,
// mouse packet payload and the keyboard scan codes used by the game logic.
package ps2_pkg;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } byte_idx_e;

  localparam int unsigned HDR_LEFT   = 0;
  localparam int unsigned HDR_RIGHT  = 1;
  localparam int unsigned HDR_MIDDLE = 2;
  localparam int unsigned HDR_SYNC   = 3;
  localparam int unsigned HDR_XS     = 4;
  localparam int unsigned HDR_YS     = 5;
  localparam int unsigned HDR_XO     = 6;
  localparam int unsigned HDR_YO     = 7;

  localparam logic [7:0] SC_EXTENDED = 8'hE0;
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_W        = 8'h1D;
  localparam logic [7:0] SC_A        = 8'h1C;
  localparam logic [7:0] SC_S        = 8'h1B;
  localparam logic [7:0] SC_D        = 8'h23;
  localparam logic [7:0] SC_SPACE    = 8'h29;

  typedef struct packed {
    logic [7:0] hdr;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [7:0] wz;
  } mouse_pkt_t;

  // 9-bit two's complement movement from header sign bit and data byte
  function automatic logic [8:0] delta9(input logic sign, input logic [7:0] mag);
    return {sign, mag};
  endfunction

endpackage

// File: rtl/ps2_axis_clamp.sv
// One cursor axis: adds (or subtracts) a 9-bit signed delta and clamps the
// result to 0..EXTENT-1 so the position never wraps.
module ps2_axis_clamp #(
  parameter int unsigned EXTENT = 320,
  parameter int unsigned WIDTH  = 9,
  parameter bit          INVERT = 1'b0
) (
  input  logic [WIDTH-1:0] pos,
  input  logic [8:0]       delta,
  input  logic             ovf,
  output logic [WIDTH-1:0] next_pos_c
);

  // Two guard bits over the position, and never narrower than the delta plus sign
  localparam int unsigned SUM_W = (WIDTH + 2 > 10) ? WIDTH + 2 : 10;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(EXTENT - 1);

  logic signed [SUM_W-1:0] pos_s;
  logic signed [SUM_W-1:0] dlt_s;
  logic signed [SUM_W-1:0] sum_s;

  always_comb begin
    pos_s = $signed({{(SUM_W-WIDTH){1'b0}}, pos});
    dlt_s = ovf ? '0 : $signed({{(SUM_W-9){delta[8]}}, delta});
    sum_s = INVERT ? (pos_s - dlt_s) : (pos_s + dlt_s);
    if (sum_s[SUM_W-1]) begin
      next_pos_c = '0;
    end else if (sum_s > MAX_S) begin
      next_pos_c = WIDTH'(EXTENT - 1);
    end else begin
      next_pos_c = sum_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/ps2_mouse_packet_tracker.sv
// Assembles PS/2 mouse packets from the byte stream, resynchronises on framing
// errors and timeouts, and tracks a clamped on-screen cursor.
module ps2_mouse_packet_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned SCREEN_W       = 320,
  parameter int unsigned SCREEN_H       = 240,
  parameter int unsigned WHEEL_EN       = 0,
  parameter int unsigned INVERT_Y       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned X_W            = $clog2(SCREEN_W),
  parameter int unsigned Y_W            = $clog2(SCREEN_H)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     byte_in,
  input  logic           byte_valid,
  input  logic           recenter,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  output logic [2:0]     buttons,
  output logic [3:0]     wheel,
  output logic           packet_valid,
  output logic           sync_error,
  output logic           overflow_seen
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [X_W-1:0] X_CTR = X_W'(SCREEN_W / 2);
  localparam logic [Y_W-1:0] Y_CTR = Y_W'(SCREEN_H / 2);

  byte_idx_e        idx;
  byte_idx_e        cur_idx_c;
  mouse_pkt_t       pkt;
  logic             pend;
  logic [TMR_W-1:0] timer;
  logic             expire_c;
  logic [X_W-1:0]   x_next_c;
  logic [Y_W-1:0]   y_next_c;

  // An expiring timer forces the current byte to be judged as a header
  assign expire_c  = (idx != B0) && (timer == TMR_MAX);
  assign cur_idx_c = expire_c ? B0 : idx;

  ps2_axis_clamp #(.EXTENT(SCREEN_W), .WIDTH(X_W), .INVERT(1'b0)) u_x_clamp (
    .pos       (x_pos),
    .delta     (delta9(pkt.hdr[HDR_XS], pkt.dx)),
    .ovf       (pkt.hdr[HDR_XO]),
    .next_pos_c(x_next_c)
  );

  ps2_axis_clamp #(.EXTENT(SCREEN_H), .WIDTH(Y_W), .INVERT(INVERT_Y != 0)) u_y_clamp (
    .pos       (y_pos),
    .delta     (delta9(pkt.hdr[HDR_YS], pkt.dy)),
    .ovf       (pkt.hdr[HDR_YO]),
    .next_pos_c(y_next_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= B0;
      pkt           <= '0;
      pend          <= 1'b0;
      timer         <= '0;
      x_pos         <= X_CTR;
      y_pos         <= Y_CTR;
      buttons       <= '0;
      wheel         <= '0;
      packet_valid  <= 1'b0;
      sync_error    <= 1'b0;
      overflow_seen <= 1'b0;
    end else begin
      packet_valid  <= 1'b0;
      sync_error    <= expire_c;
      overflow_seen <= 1'b0;
      pend          <= 1'b0;

      if (cur_idx_c == B0 || byte_valid) begin
        timer <= '0;
      end else begin
        timer <= timer + TMR_W'(1);
      end

      if (expire_c) begin
        idx <= B0;
      end

      if (byte_valid) begin
        case (cur_idx_c)
          B0: begin
            if (byte_in[HDR_SYNC]) begin
              pkt.hdr <= byte_in;
              idx     <= B1;
            end else begin
              sync_error <= 1'b1;
              idx        <= B0;
            end
          end
          B1: begin
            pkt.dx <= byte_in;
            idx    <= B2;
          end
          B2: begin
            pkt.dy <= byte_in;
            if (WHEEL_EN != 0) begin
              idx <= B3;
            end else begin
              idx  <= B0;
              pend <= 1'b1;
            end
          end
          default: begin
            pkt.wz <= byte_in;
            idx    <= B0;
            pend   <= 1'b1;
          end
        endcase
      end

      // Packet completed on the previous edge is applied here
      if (pend) begin
        packet_valid  <= 1'b1;
        buttons       <= pkt.hdr[HDR_MIDDLE:HDR_LEFT];
        wheel         <= (WHEEL_EN != 0) ? pkt.wz[3:0] : 4'd0;
        overflow_seen <= pkt.hdr[HDR_XO] | pkt.hdr[HDR_YO];
        x_pos         <= x_next_c;
        y_pos         <= y_next_c;
      end

      if (recenter) begin
        x_pos <= X_CTR;
        y_pos <= Y_CTR;
      end
    end
  end

endmodule
